wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
// - Producer side of the register file write port: merges ALU results and load-unit returns into a single registered write (en/addr/data).
// - ALU results have priority. Load returns are aligned and sign/zero-extended, then buffered in order until the port is free.
// - Provides a pending-load scoreboard so decode can interlock on rs1/rs2.
// - Raises a stall request when loads are being starved.
// PARAMETERS
// - LD_DEPTH      4  load-return FIFO entries (power of 2, >=2)
// - STARVE_LIMIT  4  consecutive ALU-won cycles with FIFO non-empty before alu_stall_o
// PORTS
// - clk            in   1   single clock; all state on posedge
// - rst            in   1   reset: one clock; reset is synchronous and active-high
// - alu_valid_i    in   1   ALU writeback result valid (no backpressure; always consumed)
// - alu_rd_i       in   5   ALU destination register
// - alu_data_i     in   32  ALU result
// - ld_valid_i     in   1   load return valid
// - ld_ready_o     out  1   load return accepted when valid&&ready
// - ld_rd_i        in   5   load destination register
// - ld_funct3_i    in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// - ld_off_i       in   2   byte offset of access within word
// - ld_data_i      in   32  raw memory word
// - rs1_addr_i     in   5   scoreboard query 1
// - rs2_addr_i     in   5   scoreboard query 2
// - rs1_busy_o     out  1   rs1 has a queued load write pending
// - rs2_busy_o     out  1   rs2 has a queued load write pending
// - alu_stall_o    out  1   request pipeline bubble so FIFO can drain
// - reg_wr_en_o    out  1   register file write enable
// - reg_wr_addr_o  out  5   register file write address
// - reg_wr_data_o  out  32  register file write data
// BEHAVIOUR
// - Reset: reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0, alu_stall_o=0.
//   FIFO emptied (all entries invalid), starve counter=0; ld_ready_o=1 the cycle after reset releases.
// - Reset mid-operation discards queued loads; the upstream side is reset together with this block.
// - Write-port outputs are registered: selection in cycle N appears on reg_wr_* in N+1, for exactly one cycle.
// - Per-cycle priority:
//   (1) alu_valid_i;
//   (2) FIFO head;
//   (3) incoming accepted load, bypassing the FIFO only when FIFO is empty and no ALU.
//   - An accepted load that is not written this cycle is enqueued at the tail.
// - ld_ready_o = !fifo_full, combinational. Full with simultaneous pop still reports not-ready (no same-cycle slot reuse).
// - Load align: shifted = ld_data_i >> (8*ld_off_i).
//   - LB: sext(shifted[7:0]); LBU: zext(shifted[7:0])
//   - LH: sext(shifted[15:0]); LHU: zext(shifted[15:0])
//   - LW and undefined funct3: ld_data_i unshifted
//   - Misaligned LH/LW are blocked upstream; the result is deterministic but unspecified.
// - rd=x0: ALU result produces reg_wr_en_o=0. A load to x0 is accepted but never enqueued or written.
// - WAW: an ALU write in cycle N to rd R invalidates every valid FIFO entry with rd R.
//   - Killed entries are popped without a write when they reach the head; popping a killed head does not block the ALU or the next entry.
//   - A load accepted in the same cycle as an ALU write to the same R is younger and is kept.
// - Scoreboard: rsX_busy_o = any valid, non-killed FIFO entry with rd==rsX_addr_i. Combinational from FIFO state only. x0 is never busy.
// - Starvation counter:
//   - Increments when the ALU wins and the FIFO holds a valid entry; clears otherwise.
//   - At STARVE_LIMIT, alu_stall_o=1 for one cycle (registered), then the counter clears.
//   - Upstream guarantees alu_valid_i=0 in the cycle after alu_stall_o.
// - FIFO pointers are log2(LD_DEPTH)+1 bits with wrap bit; full/empty are decided by pointer compare.
// STRUCTURE
// - defines.v: REG_ADDR_WIDTH, DATA_WIDTH, REG_ZERO, load funct3 codes (LB/LH/LW/LBU/LHU).
// - Sub-module wb_load_fifo holds the ordered buffer plus per-entry valid/kill bits and the rd compare for scoreboard and WAW kill.
// - Alignment, arbitration and the starve counter live in the top module.
// TESTING
// - ALU-only: alu_valid=1, rd=5, data=0x1234 in N -> reg_wr_en=1, addr=5, data=0x1234 in N+1; rd=0 -> reg_wr_en=0.
// - Align: ld_data=0x80FF7F01 with LB/off1, LBU/off1, LH/off2, LHU/off2
//   -> 0x0000007F, 0x0000007F, 0xFFFF80FF, 0x000080FF.
// - Contention: ALU valid 6 cycles while 4 loads arrive (LD_DEPTH=4)
//   -> ld_ready=0 once full; alu_stall pulse after 4 ALU wins; loads drain in order.
// - WAW kill: load to x7 queued, then ALU writes x7=0xAA
//   -> rs1_busy(x7) drops the next cycle; no later write to x7; x7 final value is 0xAA.
// - Reset mid-drain: 3 loads queued, rst for 1 cycle
//   -> reg_wr_en=0, busy outputs 0, ld_ready=1; no queued write appears afterwards.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice: register/data widths,
// the x0 address, load funct3 encodings and the load-return alignment helper.
package wb_write_arbiter_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int DATA_WIDTH     = 32;

   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } ld_funct3_e;

   // Shift the addressed byte/halfword down to bit 0, then extend.
   // LW and any unknown funct3 pass the raw word through unshifted.
   function automatic logic [DATA_WIDTH-1:0] load_align(
      input logic [DATA_WIDTH-1:0] raw,
      input logic [2:0]            funct3,
      input logic [1:0]            off
   );
      logic [DATA_WIDTH-1:0] shifted;
      shifted = raw >> {off, 3'b000};
      case (funct3)
         F3_LB:   load_align = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  load_align = {24'd0, shifted[7:0]};
         F3_LH:   load_align = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  load_align = {16'd0, shifted[15:0]};
         default: load_align = raw;
      endcase
   endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Ordered buffer of aligned load returns waiting for the register write port.
// Each entry carries valid and kill bits; the rd of every entry is compared
// against the two scoreboard queries and against the ALU write (WAW kill).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_en/rd/data     enqueue an aligned load at the tail
//   pop_en              retire the head (written or killed)
//   kill_en, kill_rd    mark every valid entry with rd==kill_rd as killed
//   q1_addr, q2_addr    scoreboard queries
//   empty, full         pointer-compare status
//   head_killed/rd/data head entry contents
//   q1_busy, q2_busy    a live (valid, not killed) entry targets the query
module wb_load_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_en,
   input  logic [REG_ADDR_WIDTH-1:0] push_rd,
   input  logic [DATA_WIDTH-1:0]     push_data,
   input  logic                      pop_en,
   input  logic                      kill_en,
   input  logic [REG_ADDR_WIDTH-1:0] kill_rd,
   input  logic [REG_ADDR_WIDTH-1:0] q1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] q2_addr,
   output logic                      empty,
   output logic                      full,
   output logic                      head_killed,
   output logic [REG_ADDR_WIDTH-1:0] head_rd,
   output logic [DATA_WIDTH-1:0]     head_data,
   output logic                      q1_busy,
   output logic                      q2_busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   // Pointers carry a wrap bit so full and empty are distinguishable.
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [IDX_W-1:0]          wr_idx, rd_idx;
   logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
   logic [DATA_WIDTH-1:0]     data_mem [DEPTH];
   logic [DEPTH-1:0]          valid_q, kill_q;

   assign wr_idx = wr_ptr[IDX_W-1:0];
   assign rd_idx = rd_ptr[IDX_W-1:0];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

   assign head_killed = kill_q[rd_idx];
   assign head_rd     = rd_mem[rd_idx];
   assign head_data   = data_mem[rd_idx];

   // NOTE: payload storage has no reset; the valid bits and pointers alone
   // decide which entries mean anything, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (push_en) begin
         rd_mem[wr_idx]   <= push_rd;
         data_mem[wr_idx] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every reader
   // sees the pre-edge value regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         valid_q <= '0;
         kill_q  <= '0;
      end else begin
         // Kill only existing entries; a same-cycle push is younger and is
         // written after this loop so it lands with kill cleared.
         if (kill_en) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && (rd_mem[i] == kill_rd)) kill_q[i] <= 1'b1;
            end
         end
         if (pop_en) begin
            valid_q[rd_idx] <= 1'b0;
            rd_ptr          <= rd_ptr + PTR_W'(1);
         end
         if (push_en) begin
            valid_q[wr_idx] <= 1'b1;
            kill_q[wr_idx]  <= 1'b0;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // NOTE: both outputs get a default before the loop so no latch is inferred.
   always_comb begin
      q1_busy = 1'b0;
      q2_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !kill_q[i]) begin
            if (rd_mem[i] == q1_addr) q1_busy = 1'b1;
            if (rd_mem[i] == q2_addr) q2_busy = 1'b1;
         end
      end
      if (q1_addr == REG_ZERO) q1_busy = 1'b0;
      if (q2_addr == REG_ZERO) q2_busy = 1'b0;
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register file write-port producer. Merges ALU results (highest priority)
// with aligned load returns (buffered in order) into one registered write,
// exposes a pending-load scoreboard and requests a bubble when loads starve.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid_i/rd_i/data_i       ALU writeback (always consumed)
//   ld_valid_i/ld_ready_o         load return handshake
//   ld_rd_i/funct3_i/off_i/data_i load destination, type, byte offset, raw word
//   rs1_addr_i/rs2_addr_i         scoreboard queries
//   rs1_busy_o/rs2_busy_o         query has a queued load write pending
//   alu_stall_o                   one-cycle bubble request
//   reg_wr_en_o/addr_o/data_o     registered register file write
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int LD_DEPTH     = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      alu_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd_i,
   input  logic [DATA_WIDTH-1:0]     alu_data_i,
   input  logic                      ld_valid_i,
   output logic                      ld_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0] ld_rd_i,
   input  logic [2:0]                ld_funct3_i,
   input  logic [1:0]                ld_off_i,
   input  logic [DATA_WIDTH-1:0]     ld_data_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
   output logic                      rs1_busy_o,
   output logic                      rs2_busy_o,
   output logic                      alu_stall_o,
   output logic                      reg_wr_en_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     reg_wr_data_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic                      fifo_empty, fifo_full;
   logic                      head_killed;
   logic [REG_ADDR_WIDTH-1:0] head_rd;
   logic [DATA_WIDTH-1:0]     head_data;
   logic                      ld_accept, ld_live;
   logic [DATA_WIDTH-1:0]     ld_aligned;
   logic                      bypass, push, pop, kill_en;
   logic                      sel_en;
   logic [REG_ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0]     sel_data;
   logic [CNT_W-1:0]          starve_cnt;

   // Full with a same-cycle pop still refuses: no slot reuse in one cycle.
   assign ld_ready_o = !fifo_full;
   assign ld_accept  = ld_valid_i && !fifo_full;
   // Loads to x0 are accepted and silently dropped.
   assign ld_live    = ld_accept && (ld_rd_i != REG_ZERO);
   assign ld_aligned = load_align(ld_data_i, ld_funct3_i, ld_off_i);
   assign kill_en    = alu_valid_i && (alu_rd_i != REG_ZERO);

   always_comb begin
      sel_en   = 1'b0;
      sel_addr = alu_rd_i;
      sel_data = alu_data_i;
      pop      = 1'b0;
      bypass   = 1'b0;
      if (alu_valid_i) begin
         sel_en = (alu_rd_i != REG_ZERO);
      end else if (!fifo_empty) begin
         pop      = 1'b1;
         sel_en   = !head_killed;
         sel_addr = head_rd;
         sel_data = head_data;
      end else if (ld_live) begin
         bypass   = 1'b1;
         sel_en   = 1'b1;
         sel_addr = ld_rd_i;
         sel_data = ld_aligned;
      end
      // A killed head needs no port slot, so it retires under an ALU write too.
      if (alu_valid_i && !fifo_empty && head_killed) pop = 1'b1;
   end

   assign push = ld_live && !bypass;

   wb_load_fifo #(
      .DEPTH (LD_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_en     (push),
      .push_rd     (ld_rd_i),
      .push_data   (ld_aligned),
      .pop_en      (pop),
      .kill_en     (kill_en),
      .kill_rd     (alu_rd_i),
      .q1_addr     (rs1_addr_i),
      .q2_addr     (rs2_addr_i),
      .empty       (fifo_empty),
      .full        (fifo_full),
      .head_killed (head_killed),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .q1_busy     (rs1_busy_o),
      .q2_busy     (rs2_busy_o)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_wr_en_o   <= 1'b0;
         reg_wr_addr_o <= '0;
         reg_wr_data_o <= '0;
         alu_stall_o   <= 1'b0;
         starve_cnt    <= '0;
      end else begin
         reg_wr_en_o   <= sel_en;
         reg_wr_addr_o <= sel_addr;
         reg_wr_data_o <= sel_data;
         // Count ALU wins while loads wait; the limit-th win fires one
         // registered stall pulse and restarts the count.
         if (alu_valid_i && !fifo_empty) begin
            if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
               alu_stall_o <= 1'b1;
               starve_cnt  <= '0;
            end else begin
               alu_stall_o <= 1'b0;
               starve_cnt  <= starve_cnt + CNT_W'(1);
            end
         end else begin
            alu_stall_o <= 1'b0;
            starve_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;

   localparam int LD_DEPTH     = 4;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid_i = 1'b0;
   logic [4:0]  alu_rd_i = '0;
   logic [31:0] alu_data_i = '0;
   logic        ld_valid_i = 1'b0;
   logic        ld_ready_o;
   logic [4:0]  ld_rd_i = '0;
   logic [2:0]  ld_funct3_i = '0;
   logic [1:0]  ld_off_i = '0;
   logic [31:0] ld_data_i = '0;
   logic [4:0]  rs1_addr_i = '0;
   logic [4:0]  rs2_addr_i = '0;
   logic        rs1_busy_o, rs2_busy_o, alu_stall_o;
   logic        reg_wr_en_o;
   logic [4:0]  reg_wr_addr_o;
   logic [31:0] reg_wr_data_o;

   int n_checks = 0;
   int n_errors = 0;

   wb_write_arbiter #(
      .LD_DEPTH     (LD_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid_i   (alu_valid_i),
      .alu_rd_i      (alu_rd_i),
      .alu_data_i    (alu_data_i),
      .ld_valid_i    (ld_valid_i),
      .ld_ready_o    (ld_ready_o),
      .ld_rd_i       (ld_rd_i),
      .ld_funct3_i   (ld_funct3_i),
      .ld_off_i      (ld_off_i),
      .ld_data_i     (ld_data_i),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .rs1_busy_o    (rs1_busy_o),
      .rs2_busy_o    (rs2_busy_o),
      .alu_stall_o   (alu_stall_o),
      .reg_wr_en_o   (reg_wr_en_o),
      .reg_wr_addr_o (reg_wr_addr_o),
      .reg_wr_data_o (reg_wr_data_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          killed;
   } ent_t;

   ent_t        mq[$];
   bit          model_live = 0;
   int          m_cnt = 0;
   int          m_n0;
   ent_t        m_e;
   logic [31:0] m_al;
   bit          exp_en = 0, exp_stall = 0;
   logic [4:0]  exp_addr = '0;
   logic [31:0] exp_data = '0;
   logic [31:0] shadow [32];

   function automatic logic [31:0] ref_align(logic [31:0] raw, logic [2:0] f3, logic [1:0] off);
      int unsigned w, b, h;
      w = raw >> (8 * off);
      b = w % 256;
      h = w % 65536;
      case (f3)
         3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'b100:  return b;
         3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'b101:  return h;
         default: return raw;
      endcase
   endfunction

   function automatic bit model_busy(logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      foreach (mq[i]) if (!mq[i].killed && mq[i].rd == a) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_cnt      = 0;
         exp_en     = 0;
         exp_addr   = '0;
         exp_data   = '0;
         exp_stall  = 0;
         model_live = 1;
      end else begin
         m_n0   = mq.size();
         exp_en = 0;
         if (alu_valid_i) begin
            exp_en   = (alu_rd_i != 5'd0);
            exp_addr = alu_rd_i;
            exp_data = alu_data_i;
            if (m_n0 > 0 && mq[0].killed) void'(mq.pop_front());
            foreach (mq[i]) if (mq[i].rd == alu_rd_i) mq[i].killed = 1;
         end else if (m_n0 > 0) begin
            m_e = mq.pop_front();
            if (!m_e.killed) begin
               exp_en   = 1;
               exp_addr = m_e.rd;
               exp_data = m_e.data;
            end
         end
         if (ld_valid_i && (m_n0 < LD_DEPTH) && ld_rd_i != 5'd0) begin
            m_al = ref_align(ld_data_i, ld_funct3_i, ld_off_i);
            if (!alu_valid_i && m_n0 == 0) begin
               exp_en   = 1;
               exp_addr = ld_rd_i;
               exp_data = m_al;
            end else begin
               mq.push_back('{rd: ld_rd_i, data: m_al, killed: 1'b0});
            end
         end
         if (alu_valid_i && m_n0 > 0) begin
            m_cnt++;
            exp_stall = (m_cnt == STARVE_LIMIT);
            if (exp_stall) m_cnt = 0;
         end else begin
            m_cnt     = 0;
            exp_stall = 0;
         end
      end
   end

   // Compare DUT against the model every cycle once reset has been seen.
   always @(posedge clk) begin
      #1;
      if (model_live) begin
         check("wr_en", {31'd0, reg_wr_en_o}, {31'd0, exp_en});
         if (exp_en) begin
            check("wr_addr", {27'd0, reg_wr_addr_o}, {27'd0, exp_addr});
            check("wr_data", reg_wr_data_o, exp_data);
         end
         check("alu_stall", {31'd0, alu_stall_o}, {31'd0, exp_stall});
         check("ld_ready", {31'd0, ld_ready_o}, {31'd0, (mq.size() < LD_DEPTH)});
         check("rs1_busy", {31'd0, rs1_busy_o}, {31'd0, model_busy(rs1_addr_i)});
         check("rs2_busy", {31'd0, rs2_busy_o}, {31'd0, model_busy(rs2_addr_i)});
         if (reg_wr_en_o) shadow[reg_wr_addr_o] = reg_wr_data_o;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] ld);
      @(negedge clk);
      rst         = r;
      alu_valid_i = av;
      alu_rd_i    = ard;
      alu_data_i  = ad;
      ld_valid_i  = lv;
      ld_rd_i     = lrd;
      ld_funct3_i = f3;
      ld_off_i    = off;
      ld_data_i   = ld;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 32'd0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin
      foreach (shadow[i]) shadow[i] = '0;

      // Reset
      drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      after_edge();
      check("rst_wr_en", {31'd0, reg_wr_en_o}, 32'd0);
      check("rst_wr_addr", {27'd0, reg_wr_addr_o}, 32'd0);
      check("rst_wr_data", reg_wr_data_o, 32'd0);
      check("rst_stall", {31'd0, alu_stall_o}, 32'd0);
      idle(1);
      after_edge();
      check("rst_ready", {31'd0, ld_ready_o}, 32'd1);

      // ALU only
      drive(0, 1, 5'd5, 32'h1234, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      after_edge();
      check("alu_en", {31'd0, reg_wr_en_o}, 32'd1);
      check("alu_addr", {27'd0, reg_wr_addr_o}, 32'd5);
      check("alu_data", reg_wr_data_o, 32'h1234);
      drive(0, 1, 5'd0, 32'hDEAD, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      after_edge();
      check("alu_x0_en", {31'd0, reg_wr_en_o}, 32'd0);

      // Alignment through the bypass path
      drive(0, 0, 5'd0, 32'd0, 1, 5'd1, 3'b000, 2'd1, 32'h80FF7F01);
      after_edge();
      check("lb_off1", reg_wr_data_o, 32'h0000007F);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd2, 3'b100, 2'd1, 32'h80FF7F01);
      after_edge();
      check("lbu_off1", reg_wr_data_o, 32'h0000007F);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd3, 3'b001, 2'd2, 32'h80FF7F01);
      after_edge();
      check("lh_off2", reg_wr_data_o, 32'hFFFF80FF);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd4, 3'b101, 2'd2, 32'h80FF7F01);
      after_edge();
      check("lhu_off2", reg_wr_data_o, 32'h000080FF);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd6, 3'b010, 2'd0, 32'h80FF7F01);
      after_edge();
      check("lw_off0", reg_wr_data_o, 32'h80FF7F01);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 3'b010, 2'd0, 32'h5555AAAA);
      after_edge();
      check("ld_x0_en", {31'd0, reg_wr_en_o}, 32'd0);

      // Contention: ALU keeps winning while loads fill the FIFO
      rs1_addr_i = 5'd20;
      rs2_addr_i = 5'd23;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 5'(10 + i), 32'h100 + i, 1, 5'(20 + i), 3'b010, 2'd0, 32'hA0 + i);
      end
      after_edge();
      check("full_ready", {31'd0, ld_ready_o}, 32'd0);
      check("full_busy1", {31'd0, rs1_busy_o}, 32'd1);
      drive(0, 1, 5'd14, 32'h104, 1, 5'd24, 3'b010, 2'd0, 32'hA4);
      after_edge();
      check("starve_stall", {31'd0, alu_stall_o}, 32'd1);
      drive(0, 0, 5'd0, 32'd0, 1, 5'd24, 3'b010, 2'd0, 32'hA4);
      after_edge();
      check("drain_first_addr", {27'd0, reg_wr_addr_o}, 32'd20);
      drive(0, 1, 5'd15, 32'h105, 1, 5'd24, 3'b010, 2'd0, 32'hA4);
      idle(6);

      // WAW kill
      rs1_addr_i = 5'd7;
      rs2_addr_i = 5'd8;
      drive(0, 1, 5'd1, 32'h11, 1, 5'd7, 3'b010, 2'd0, 32'h77);
      after_edge();
      check("waw_busy_set", {31'd0, rs1_busy_o}, 32'd1);
      drive(0, 1, 5'd7, 32'hAA, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      after_edge();
      check("waw_busy_drop", {31'd0, rs1_busy_o}, 32'd0);
      idle(4);
      check("waw_x7_final", shadow[7], 32'hAA);
      drive(0, 1, 5'd9, 32'h1, 1, 5'd8, 3'b010, 2'd0, 32'h88);
      drive(0, 1, 5'd8, 32'h5, 1, 5'd8, 3'b010, 2'd0, 32'h66);
      after_edge();
      check("waw_young_kept", {31'd0, rs2_busy_o}, 32'd1);
      idle(4);
      check("waw_x8_final", shadow[8], 32'h66);

      // Reset in the middle of a drain
      rs1_addr_i = 5'd30;
      rs2_addr_i = 5'd31;
      drive(0, 1, 5'd2, 32'h20, 1, 5'd30, 3'b010, 2'd0, 32'hC0);
      drive(0, 1, 5'd2, 32'h21, 1, 5'd31, 3'b010, 2'd0, 32'hC1);
      drive(0, 1, 5'd2, 32'h22, 1, 5'd29, 3'b010, 2'd0, 32'hC2);
      drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      after_edge();
      check("mid_rst_en", {31'd0, reg_wr_en_o}, 32'd0);
      check("mid_rst_busy1", {31'd0, rs1_busy_o}, 32'd0);
      check("mid_rst_busy2", {31'd0, rs2_busy_o}, 32'd0);
      check("mid_rst_ready", {31'd0, ld_ready_o}, 32'd1);
      idle(5);
      check("mid_rst_x30", shadow[30], 32'd0);
      check("mid_rst_x31", shadow[31], 32'd0);
      check("mid_rst_x29", shadow[29], 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
